mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 195 +++++++++++++++++++
 tb/tb_mem_access.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// rtl/mem_access.sv - pipeline memory-access stage with data-bus handshake, timeout and writeback
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   mem_command_in[1:0] 00 none, 01 load, 10 store, 11 none
//   inst_in[31:0]       instruction (funct3 = inst_in[14:12] selects size)
//   alu_in[31:0]        byte address for load/store, writeback value otherwise
//   wdata_in[31:0]      store data, rd_in[4:0] destination register
//   dmem_*              registered data-bus request (req/we/addr/wdata/be), ack/rdata response
//   stop                combinational stall request to upstream stages
//   wb_valid, wb_data, rd_out, inst_out, access_err   registered writeback outputs
module mem_access #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mem_command_in,
    input  logic [31:0] inst_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] wdata_in,
    input  logic [4:0]  rd_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stop,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  rd_out,
    output logic [31:0] inst_out,
    output logic        access_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;

    state_t      state, state_nx;
    logic [7:0]  wait_cnt;
    logic [1:0]  addr_lo;

    logic        is_load, is_store, f3_legal, misaligned, mem_ok, mem_bad;
    logic [2:0]  funct3;
    logic [3:0]  be_nx;
    logic [31:0] wdata_nx;
    logic        timeout_hit;
    logic [31:0] rdata_shifted;
    logic [31:0] load_data;

    // Request decode, only meaningful while IDLE
    always_comb begin
        is_load  = (mem_command_in == 2'b01);
        is_store = (mem_command_in == 2'b10);
        funct3   = inst_in[14:12];
        f3_legal = 1'b0;
        if (is_load)
            f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b100) || (funct3 == 3'b101);
        else if (is_store)
            f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        // funct3[1:0] gives the size for both signed and unsigned loads
        misaligned = ((funct3[1:0] == 2'b01) && alu_in[0]) ||
                     ((funct3[1:0] == 2'b10) && (alu_in[1:0] != 2'b00));
        mem_ok  = (is_load || is_store) && f3_legal && !misaligned;
        mem_bad = (is_load || is_store) && !(f3_legal && !misaligned);

        be_nx    = 4'b1111;
        wdata_nx = 32'h0;
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    be_nx    = 4'b0001 << alu_in[1:0];
                    wdata_nx = {4{wdata_in[7:0]}};
                end
                2'b01: begin
                    be_nx    = 4'b0011 << alu_in[1:0];
                    wdata_nx = {2{wdata_in[15:0]}};
                end
                default: begin
                    be_nx    = 4'b1111;
                    wdata_nx = wdata_in;
                end
            endcase
        end
    end

    // Load result extraction uses the funct3 captured in inst_out during BUSY
    always_comb begin
        rdata_shifted = dmem_rdata >> {addr_lo, 3'b000};
        case (inst_out[14:12])
            3'b000:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b001:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b100:  load_data = {24'h0, rdata_shifted[7:0]};
            3'b101:  load_data = {16'h0, rdata_shifted[15:0]};
            default: load_data = rdata_shifted;
        endcase
    end

    // Ack has priority: an ack in the final counted cycle completes the access
    assign timeout_hit = (state == BUSY) && !dmem_ack && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Stop is released in the timeout cycle so upstream moves past the aborted access
    always_comb begin
        state_nx = state;
        stop     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_ok) begin
                    state_nx = BUSY;
                    stop     = 1'b1;
                end
            end
            BUSY: begin
                stop = !dmem_ack && !timeout_hit;
                if (dmem_ack || timeout_hit)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (rst)
            stop = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_wdata <= 32'h0;
            dmem_be    <= 4'h0;
            wb_valid   <= 1'b0;
            wb_data    <= 32'h0;
            rd_out     <= 5'h0;
            inst_out   <= 32'h0;
            access_err <= 1'b0;
            wait_cnt   <= 8'h0;
            addr_lo    <= 2'b00;
        end else begin
            wb_valid   <= 1'b0;
            access_err <= 1'b0;
            case (state)
                IDLE: begin
                    rd_out   <= rd_in;
                    inst_out <= inst_in;
                    if (mem_ok) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_store;
                        dmem_addr  <= {alu_in[31:2], 2'b00};
                        dmem_be    <= be_nx;
                        dmem_wdata <= wdata_nx;
                        addr_lo    <= alu_in[1:0];
                        wait_cnt   <= 8'h0;
                    end else if (mem_bad) begin
                        wb_data    <= alu_in;
                        access_err <= 1'b1;
                    end else begin
                        wb_data  <= alu_in;
                        wb_valid <= (inst_in != 32'h0) && (inst_in[6:0] != OP_STORE) &&
                                    (inst_in[6:0] != OP_BRANCH);
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (!dmem_we) begin
                            wb_data  <= load_data;
                            wb_valid <= (rd_out != 5'h0);
                        end
                    end else if (timeout_hit) begin
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        access_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'h1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed self-checking bench for mem_access
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mem_command_in;
    logic [31:0] inst_in, alu_in, wdata_in;
    logic [4:0]  rd_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stop, wb_valid, access_err;
    logic [31:0] wb_data, inst_out;
    logic [4:0]  rd_out;

    int errors = 0;
    int checks = 0;
    int req_cycles;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .mem_command_in(mem_command_in), .inst_in(inst_in), .alu_in(alu_in),
        .wdata_in(wdata_in), .rd_in(rd_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .stop(stop),
        .wb_valid(wb_valid), .wb_data(wb_data), .rd_out(rd_out),
        .inst_out(inst_out), .access_err(access_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] cmd, input logic [31:0] inst,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd);
        mem_command_in = cmd;
        inst_in        = inst;
        alu_in         = alu;
        wdata_in       = wd;
        rd_in          = rd;
        #1;
    endtask

    task automatic cycle;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        drive(2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
        cycle();
        cycle();
        chk("rst_req", dmem_req, 0);
        chk("rst_be", dmem_be, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_err", access_err, 0);
        chk("rst_stop", stop, 0);
        rst = 1'b0;

        // ADD x5 with alu result 0x55
        drive(2'b00, 32'h002082B3, 32'h55, 32'h0, 5'd5);
        chk("add_stop", stop, 0);
        cycle();
        chk("add_wb_data", wb_data, 32'h55);
        chk("add_rd_out", rd_out, 5);
        chk("add_wb_valid", wb_valid, 1);
        chk("add_inst_out", inst_out, 32'h002082B3);

        // LB x7 at 0x103, ack two cycles after request
        drive(2'b01, 32'h00000383, 32'h103, 32'h0, 5'd7);
        chk("lb_stop_idle", stop, 1);
        chk("lb_no_req_yet", dmem_req, 0);
        cycle();
        chk("lb_req", dmem_req, 1);
        chk("lb_addr", dmem_addr, 32'h100);
        chk("lb_be", dmem_be, 4'b1111);
        chk("lb_we", dmem_we, 0);
        chk("lb_wdata", dmem_wdata, 0);
        chk("lb_stop_busy", stop, 1);
        chk("lb_wb_valid_busy", wb_valid, 0);
        cycle();
        chk("lb_stop_wait", stop, 1);
        chk("lb_addr_held", dmem_addr, 32'h100);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h80FF1234;
        #1;
        chk("lb_stop_ack", stop, 0);
        cycle();
        chk("lb_wb_data", wb_data, 32'hFFFFFF80);
        chk("lb_wb_valid", wb_valid, 1);
        chk("lb_rd_out", rd_out, 7);
        chk("lb_req_drop", dmem_req, 0);
        dmem_ack = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
        cycle();
        chk("bubble_wb_valid", wb_valid, 0);

        // SH at 0x202, immediate ack
        drive(2'b10, 32'h00001023, 32'h202, 32'h0000ABCD, 5'd0);
        chk("sh_stop_idle", stop, 1);
        cycle();
        dmem_ack = 1'b1;
        #1;
        chk("sh_req", dmem_req, 1);
        chk("sh_we", dmem_we, 1);
        chk("sh_addr", dmem_addr, 32'h200);
        chk("sh_be", dmem_be, 4'b1100);
        chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
        chk("sh_stop_ack", stop, 0);
        cycle();
        chk("sh_req_drop", dmem_req, 0);
        chk("sh_wb_valid", wb_valid, 0);
        dmem_ack = 1'b0;

        // SB at 0x301 checks byte lane and replication
        drive(2'b10, 32'h00000023, 32'h301, 32'h000000A5, 5'd0);
        cycle();
        chk("sb_be", dmem_be, 4'b0010);
        chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
        dmem_ack = 1'b1;
        cycle();
        dmem_ack = 1'b0;

        // LW misaligned at 0x101
        drive(2'b01, 32'h00002403, 32'h101, 32'h0, 5'd8);
        chk("lw_mis_stop", stop, 0);
        cycle();
        chk("lw_mis_err", access_err, 1);
        chk("lw_mis_req", dmem_req, 0);
        chk("lw_mis_wb_valid", wb_valid, 0);
        chk("lw_mis_rd_out", rd_out, 8);
        drive(2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
        cycle();
        chk("lw_mis_err_pulse", access_err, 0);

        // Store with illegal funct3 011
        drive(2'b10, 32'h00003023, 32'h10, 32'h0, 5'd0);
        chk("sd_illegal_stop", stop, 0);
        cycle();
        chk("sd_illegal_err", access_err, 1);
        chk("sd_illegal_req", dmem_req, 0);
        drive(2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
        cycle();

        // LHU at 0x40 never acked: timeout after 16 request cycles
        drive(2'b01, 32'h00005483, 32'h40, 32'h0, 5'd9);
        cycle();
        req_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (!dmem_req) break;
            req_cycles++;
            cycle();
        end
        chk("lhu_req_cycles", req_cycles, 16);
        chk("lhu_timeout_err", access_err, 1);
        chk("lhu_timeout_wb_valid", wb_valid, 0);
        drive(2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
        chk("lhu_timeout_stop", stop, 0);
        cycle();
        chk("lhu_err_pulse", access_err, 0);
        chk("lhu_no_reissue", dmem_req, 0);

        // LW at 0x44 acked in the final counted cycle still succeeds
        drive(2'b01, 32'h00002503, 32'h44, 32'h0, 5'd10);
        cycle();
        repeat (15) cycle();
        chk("lw_edge_req", dmem_req, 1);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h12345678;
        cycle();
        chk("lw_edge_wb_valid", wb_valid, 1);
        chk("lw_edge_wb_data", wb_data, 32'h12345678);
        chk("lw_edge_err", access_err, 0);
        dmem_ack = 1'b0;

        // LH at 0x42 picks upper half and sign-extends
        drive(2'b01, 32'h00001583, 32'h42, 32'h0, 5'd11);
        cycle();
        dmem_ack = 1'b1;
        dmem_rdata = 32'h80010000;
        cycle();
        chk("lh_wb_data", wb_data, 32'hFFFF8001);
        dmem_ack = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
        cycle();

        // Reset one cycle into BUSY abandons the access
        drive(2'b01, 32'h00002603, 32'h48, 32'h0, 5'd12);
        cycle();
        chk("rstbusy_req_before", dmem_req, 1);
        rst = 1'b1;
        #1;
        chk("rstbusy_stop", stop, 0);
        cycle();
        chk("rstbusy_req", dmem_req, 0);
        chk("rstbusy_addr", dmem_addr, 0);
        chk("rstbusy_rd_out", rd_out, 0);
        chk("rstbusy_inst_out", inst_out, 0);
        chk("rstbusy_err", access_err, 0);
        rst = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        cycle();
        chk("late_ack_wb_valid", wb_valid, 0);
        chk("late_ack_req", dmem_req, 0);
        chk("late_ack_err", access_err, 0);
        dmem_ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
